matrix_op_sequencer: RTL and testbench

Instruction sequencer for the 16-bit RISC matrix engine. It fetches 9-bit instructions (opcode[8:6], dest[5:3], src[2:0]) from a synchronous instruction memory using its own program counter. It decodes each instruction and issues it to the matrix datapath (register/RAM loader plus ALU) over a valid/ready/done handshake. NO-OPs are retired internally; STOP halts execution until the next run pulse.

---
 rtl/matrix_engine_pkg.sv | 30 +++
 rtl/seq_inst_reg.sv | 32 +++
 rtl/matrix_op_sequencer.sv | 120 ++++++++++++
 tb/tb_matrix_op_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_engine_pkg.sv
// Shared definitions for the 16-bit RISC matrix engine: instruction layout,
// opcodes and the sequencer state encoding.
package matrix_engine_pkg;

   localparam int INST_W = 9;

   localparam int OPC_HI = 8;
   localparam int OPC_LO = 6;
   localparam int DST_HI = 5;
   localparam int DST_LO = 3;
   localparam int SRC_HI = 2;
   localparam int SRC_LO = 0;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_SMUL = 3'b100;
   localparam logic [2:0] OP_MMUL = 3'b101;
   localparam logic [2:0] OP_TRAN = 3'b110;
   localparam logic [2:0] OP_STOP = 3'b111;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_ISSUE  = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

endpackage

// File: rtl/seq_inst_reg.sv
// Instruction register of the matrix op sequencer: captures the fetched word
// and splits it into the command fields presented to the datapath.
module seq_inst_reg
   import matrix_engine_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              capture,
   input  logic              issue,
   input  logic [INST_W-1:0] inst_mem,
   output logic              op_valid,
   output logic [2:0]        op_code,
   output logic [2:0]        op_dest,
   output logic [2:0]        op_src
);

   logic [INST_W-1:0] inst_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         inst_q <= '0;
      else if (capture)
         inst_q <= inst_mem;
   end

   // Fields come straight from the register, so they cannot move while issued
   assign op_valid = issue;
   assign op_code  = inst_q[OPC_HI:OPC_LO];
   assign op_dest  = inst_q[DST_HI:DST_LO];
   assign op_src   = inst_q[SRC_HI:SRC_LO];

endmodule

// File: rtl/matrix_op_sequencer.sv
// Fetch/decode/issue sequencer for the matrix engine datapath.
// Optional WAIT watchdog built when SEQ_TIMEOUT_EN is defined.
module matrix_op_sequencer
   import matrix_engine_pkg::*;
#(
   parameter int ADDR_W         = 6,
   parameter int CNT_W          = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] program_address,
   input  logic [INST_W-1:0] inst_mem,
   output logic              op_valid,
   output logic [2:0]        op_code,
   output logic [2:0]        op_dest,
   output logic [2:0]        op_src,
   input  logic              op_ready,
   input  logic              op_done,
   output logic              busy,
   output logic              halted,
   output logic [CNT_W-1:0]  retired,
   output logic              timeout_err
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [2:0] state;
   logic       wd_expire;

   seq_inst_reg u_inst_reg (
      .clk      (clk),
      .reset    (reset),
      .capture  (state == ST_FETCH),
      .issue    (state == ST_ISSUE),
      .inst_mem (inst_mem),
      .op_valid (op_valid),
      .op_code  (op_code),
      .op_dest  (op_dest),
      .op_src   (op_src)
   );

   assign busy   = (state != ST_IDLE) && (state != ST_HALT);
   assign halted = (state == ST_HALT);

`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] wd_cnt;

   assign wd_expire = (state == ST_WAIT) && !op_done &&
                      (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Counter sits at zero outside WAIT, so it restarts on every WAIT entry
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         wd_cnt <= (state == ST_WAIT) ? wd_cnt + 1'b1 : '0;
         if (run && !busy)
            timeout_err <= 1'b0;
         else if (wd_expire)
            timeout_err <= 1'b1;
      end
   end
`else
   logic unused_timeout;

   assign wd_expire      = 1'b0;
   assign timeout_err    = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         program_address <= '0;
         retired         <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT:
               if (run) begin
                  program_address <= '0;
                  state           <= ST_FETCH;
               end
            ST_FETCH:
               state <= ST_DECODE;
            ST_DECODE:
               if (op_code == OP_NOP) begin
                  retired         <= sat_inc(retired);
                  program_address <= program_address + 1'b1;
                  state           <= ST_FETCH;
               end else if (op_code == OP_STOP) begin
                  retired <= sat_inc(retired);
                  state   <= ST_HALT;
               end else begin
                  state <= ST_ISSUE;
               end
            ST_ISSUE:
               if (op_ready)
                  state <= ST_WAIT;
            ST_WAIT:
               if (op_done) begin
                  retired         <= sat_inc(retired);
                  program_address <= program_address + 1'b1;
                  state           <= ST_FETCH;
               end else if (wd_expire) begin
                  state <= ST_HALT;
               end
            default:
               state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Randomized bench for matrix_op_sequencer with a program-level reference model.
module tb_matrix_op_sequencer;
   import matrix_engine_pkg::*;

   localparam int ADDR_W = 6;
   localparam int CNT_W  = 16;
   localparam int TO_CYC = 8;
   localparam int MEM_D  = 64;

   logic              clk;
   logic              reset;
   logic              run;
   logic [ADDR_W-1:0] program_address;
   logic [INST_W-1:0] inst_mem;
   logic              op_valid;
   logic [2:0]        op_code, op_dest, op_src;
   logic              op_ready, op_done;
   logic              busy, halted;
   logic [CNT_W-1:0]  retired;
   logic              timeout_err;

   logic [INST_W-1:0] mem [MEM_D];

   logic auto_rsp   = 1'b1;
   logic done_never = 1'b0;
   logic rsp_ready  = 1'b0;
   logic rsp_done   = 1'b0;
   logic inj_ready  = 1'b0;
   logic inj_done   = 1'b0;
   int   rdy_lat    = 0;
   int   done_lat   = 0;
   int   vld_cycles = 0;
   logic [INST_W-1:0] got_q [$];

   int n_chk = 0;
   int n_err = 0;
   int exp_ret = 0;

   int m_cyc, m_ret, m_pc;
   logic [INST_W-1:0] m_ops [$];

   assign inst_mem = mem[program_address];
   assign op_ready = rsp_ready | inj_ready;
   assign op_done  = rsp_done | inj_done;

   matrix_op_sequencer #(
      .ADDR_W         (ADDR_W),
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .run             (run),
      .program_address (program_address),
      .inst_mem        (inst_mem),
      .op_valid        (op_valid),
      .op_code         (op_code),
      .op_dest         (op_dest),
      .op_src          (op_src),
      .op_ready        (op_ready),
      .op_done         (op_done),
      .busy            (busy),
      .halted          (halted),
      .retired         (retired),
      .timeout_err     (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Datapath stand-in: ready after rdy_lat cycles of valid, done done_lat cycles into WAIT
   initial begin
      bit hs;
      bit waiting;
      int vcnt;
      int wcnt;
      hs = 0; waiting = 0; vcnt = 0; wcnt = 0;
      forever begin
         @(negedge clk);
         hs = op_valid && op_ready;
         if (op_valid) vld_cycles++;
         if (hs) got_q.push_back({op_code, op_dest, op_src});
         @(posedge clk); #1;
         if (reset) waiting = 0;
         else if (hs) begin waiting = 1; wcnt = 0; end
         vcnt = op_valid ? vcnt + 1 : 0;
         rsp_ready = auto_rsp && op_valid && (vcnt > rdy_lat);
         rsp_done = 1'b0;
         if (waiting) begin
            if (wcnt == done_lat) begin
               rsp_done = auto_rsp && !done_never;
               waiting = 0;
            end
            wcnt++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_run();
      @(posedge clk); #1;
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      exp_ret = 0;
   endtask

   // Walk the program as the engine would see it and total up the expected cost
   task automatic model_run();
      int pc;
      logic [INST_W-1:0] w;
      pc = 0; m_cyc = 0; m_ret = 0;
      m_ops.delete();
      for (int n = 0; n < MEM_D; n++) begin
         w = mem[pc];
         m_ret++;
         if (w[8:6] == OP_STOP) begin
            m_cyc += 2;
            break;
         end else if (w[8:6] == OP_NOP) begin
            m_cyc += 2;
         end else begin
            m_ops.push_back(w);
            m_cyc += 2 + (rdy_lat + 1) + (done_lat + 1);
         end
         pc = (pc + 1) % MEM_D;
      end
      m_pc = pc;
   endtask

   task automatic run_program(input string tag);
      int cyc;
      model_run();
      vld_cycles = 0;
      got_q.delete();
      pulse_run();
      cyc = 0;
      while (!halted && cyc < 2000) begin
         step(1);
         cyc++;
      end
      exp_ret = (exp_ret + m_ret > 65535) ? 65535 : exp_ret + m_ret;
      check_val({tag, "_cycles"}, cyc, m_cyc);
      check_val({tag, "_halted"}, halted, 1);
      check_val({tag, "_retired"}, retired, exp_ret);
      check_val({tag, "_pc"}, program_address, m_pc);
      check_val({tag, "_tmo"}, timeout_err, 0);
      check_val({tag, "_nops"}, got_q.size(), m_ops.size());
      for (int i = 0; i < m_ops.size() && i < got_q.size(); i++)
         check_val({tag, "_op"}, got_q[i], m_ops[i]);
   endtask

   initial begin
      int base;
      int cyc;
      int op;
      int len;
      reset = 1'b1; run = 1'b0;
      for (int i = 0; i < MEM_D; i++) mem[i] = '0;
      step(3);
      check_val("rst_pc", program_address, 0);
      check_val("rst_valid", op_valid, 0);
      check_val("rst_code", op_code, 0);
      check_val("rst_dest", op_dest, 0);
      check_val("rst_src", op_src, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_halted", halted, 0);
      check_val("rst_retired", retired, 0);
      check_val("rst_tmo", timeout_err, 0);
      reset = 1'b0;
      exp_ret = 0;

      // NOP then STOP
      mem[1] = {OP_STOP, 6'd0};
      run_program("nopstop");
      check_val("nopstop_valid_cycles", vld_cycles, 0);

      // Directed issue with a slow ready and early, ignored done pulses
      auto_rsp = 1'b0;
      mem[0] = 9'b001_010_011;
      mem[1] = {OP_STOP, 6'd0};
      base = exp_ret;
      pulse_run();
      step(2);
      for (int i = 0; i < 4; i++) begin
         check_val("iss_valid", op_valid, 1);
         check_val("iss_code", op_code, 3'b001);
         check_val("iss_dest", op_dest, 3'b010);
         check_val("iss_src", op_src, 3'b011);
         check_val("iss_pc", program_address, 0);
         inj_done = 1'b1;
         if (i == 3) inj_ready = 1'b1;
         step(1);
      end
      inj_ready = 1'b0;
      inj_done = 1'b0;
      check_val("iss_drop", op_valid, 0);
      check_val("iss_wait_busy", busy, 1);
      step(2);
      check_val("iss_wait_pc", program_address, 0);
      check_val("iss_wait_ret", retired, base);
      inj_done = 1'b1;
      step(1);
      inj_done = 1'b0;
      check_val("iss_done_pc", program_address, 1);
      check_val("iss_done_ret", retired, base + 1);
      step(2);
      check_val("iss_halt", halted, 1);
      check_val("iss_halt_ret", retired, base + 2);
      exp_ret = base + 2;
      auto_rsp = 1'b1;

      // ADD, SUB, MATR MUL, TRANSPOSE, STOP with fastest handshake
      rdy_lat = 0; done_lat = 0;
      mem[0] = {OP_ADD,  6'($urandom)};
      mem[1] = {OP_SUB,  6'($urandom)};
      mem[2] = {OP_MMUL, 6'($urandom)};
      mem[3] = {OP_TRAN, 6'($urandom)};
      mem[4] = {OP_STOP, 6'($urandom)};
      run_program("full");

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < MEM_D; i++) mem[i] = 9'($urandom);
         len = $urandom_range(3, 8);
         for (int i = 0; i < len; i++) begin
            op = $urandom_range(0, 6);
            mem[i] = {3'(op), 6'($urandom)};
         end
         mem[len] = {OP_STOP, 6'($urandom)};
         rdy_lat = $urandom_range(0, 2);
         done_lat = $urandom_range(0, 2);
         run_program("rand");
      end
      rdy_lat = 0; done_lat = 0;

      // Reset while a MATR MUL sits in WAIT
      mem[0] = {OP_NOP, 6'd0};
      mem[1] = {OP_MMUL, 6'b001_010};
      mem[2] = {OP_STOP, 6'd0};
      done_never = 1'b1;
      pulse_run();
      step(7);
      check_val("mid_pre_busy", busy, 1);
      check_val("mid_pre_pc", program_address, 1);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      check_val("mid_valid", op_valid, 0);
      check_val("mid_busy", busy, 0);
      check_val("mid_pc", program_address, 0);
      check_val("mid_ret", retired, 0);
      step(1);
      reset = 1'b0;
      exp_ret = 0;
      done_never = 1'b0;
      for (int i = 0; i < 3; i++) begin
         inj_done = 1'b1;
         step(1);
         check_val("mid_late_busy", busy, 0);
         check_val("mid_late_ret", retired, 0);
         check_val("mid_late_pc", program_address, 0);
      end
      inj_done = 1'b0;

      // All-NOP memory: PC wraps and stray run pulses change nothing
      for (int i = 0; i < MEM_D; i++) mem[i] = {OP_NOP, 6'($urandom)};
      base = exp_ret;
      pulse_run();
      for (int k = 1; k <= 70; k++) begin
         step(1);
         if (k % 9 == 0) run = 1'b1;
         step(1);
         run = 1'b0;
         check_val("wrap_pc", program_address, k % MEM_D);
         check_val("wrap_ret", retired, base + k);
      end
      do_reset();

      // A command whose done never comes
      mem[0] = {OP_ADD, 6'b011_100};
      mem[1] = {OP_STOP, 6'd0};
      done_never = 1'b1;
      base = exp_ret;
`ifdef SEQ_TIMEOUT_EN
      pulse_run();
      cyc = 0;
      while (!halted && cyc < 200) begin
         step(1);
         cyc++;
      end
      check_val("wd_cycles", cyc, 2 + (rdy_lat + 1) + TO_CYC);
      check_val("wd_err", timeout_err, 1);
      check_val("wd_halted", halted, 1);
      check_val("wd_ret", retired, base);
      check_val("wd_pc", program_address, 0);
      done_never = 1'b0;
      mem[0] = {OP_STOP, 6'd0};
      pulse_run();
      check_val("wd_clear", timeout_err, 0);
      step(2);
      check_val("wd_rerun_halt", halted, 1);
      check_val("wd_rerun_ret", retired, base + 1);
`else
      pulse_run();
      step(40);
      check_val("nowd_busy", busy, 1);
      check_val("nowd_halted", halted, 0);
      check_val("nowd_err", timeout_err, 0);
      check_val("nowd_ret", retired, base);
      done_never = 1'b0;
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
